// File: rtl/rf_writeback_arbiter_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Package : rf_writeback_arbiter_pkg
// Shared types for the RF writeback arbiter and its pending-register scoreboard.
// Rev     : 1.0
//------------------------------------------------------------------------------
package rf_writeback_arbiter_pkg;

  localparam int c_REG_W  = 5;
  localparam int c_WORD_W = 32;

  typedef logic [c_REG_W-1:0]  reg_w;
  typedef logic [c_WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_LSU  = 2'd2
  } wb_src_t;

  typedef enum logic [0:0] {
    LSU_FIRST = 1'b0,
    ALU_FIRST = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rf_writeback_arbiter_scoreboard.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : rf_scoreboard
// Pending-register mask: set on issue, clear on RF commit, sticky protocol error.
// Rev     : 1.0
//------------------------------------------------------------------------------
module rf_scoreboard
  import rf_writeback_arbiter_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_valid_i,
  input  reg_w             set_rd_i,
  input  logic             clr_valid_i,
  input  reg_w             clr_rd_i,
  output logic [NREGS-1:0] mask_o,
  output logic             err_o
);

  logic [NREGS-1:0] mask_q, mask_d;
  logic             err_q, err_d;
  logic             same_reg_clear;

  always_comb begin
    mask_d         = mask_q;
    err_d          = err_q;
    same_reg_clear = clr_valid_i && (clr_rd_i == set_rd_i);

    if (clr_valid_i) begin
      mask_d[clr_rd_i] = 1'b0;
    end

    // A set racing a clear of the same register is a fresh producer, so set wins.
    if (set_valid_i && (set_rd_i != '0)) begin
      if (mask_q[set_rd_i] && !same_reg_clear) begin
        err_d = 1'b1;
      end else begin
        mask_d[set_rd_i] = 1'b1;
      end
    end

    mask_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= '0;
      err_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      err_q  <= err_d;
    end
  end

  assign mask_o = mask_q;
  assign err_o  = err_q;

endmodule
`default_nettype wire

// File: rtl/rf_writeback_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : rf_writeback_arbiter
// Shares the RF write port between ALU and LSU (LSU priority, ALU starvation cap).
// Rev     : 1.0
//------------------------------------------------------------------------------
module rf_writeback_arbiter
  import rf_writeback_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int NREGS        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid_i,
  input  reg_w             alu_rd_i,
  input  word_t            alu_data_i,
  output logic             alu_ready_o,
  input  logic             lsu_valid_i,
  input  reg_w             lsu_rd_i,
  input  word_t            lsu_data_i,
  output logic             lsu_ready_o,
  input  logic             issue_valid_i,
  input  reg_w             issue_rd_i,
  output logic             reg_write_o,
  output reg_w             write_index_o,
  output word_t            write_data_o,
  output logic [NREGS-1:0] pending_mask_o,
  output logic             protocol_err_o
);

  localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  wb_src_t          src;
  reg_w             grant_rd;
  word_t            grant_data;
  logic             reg_write_q, reg_write_d;
  reg_w             write_index_q;
  word_t            write_data_q;

  always_comb begin
    src = WB_NONE;
    if (state_q == LSU_FIRST) begin
      if (lsu_valid_i)      src = WB_LSU;
      else if (alu_valid_i) src = WB_ALU;
    end else begin
      if (alu_valid_i)      src = WB_ALU;
      else if (lsu_valid_i) src = WB_LSU;
    end

    alu_ready_o = (src == WB_ALU);
    lsu_ready_o = (src == WB_LSU);
    grant_rd    = (src == WB_LSU) ? lsu_rd_i   : alu_rd_i;
    grant_data  = (src == WB_LSU) ? lsu_data_i : alu_data_i;
    // x0 grants complete the handshake but never reach the register file.
    reg_write_d = (src != WB_NONE) && (grant_rd != '0);

    cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == LSU_FIRST) begin
      if ((src == WB_LSU) && alu_valid_i) begin
        cnt_d = cnt_inc;
        if (cnt_inc == CNT_MAX) state_d = ALU_FIRST;
      end else begin
        cnt_d = '0;
      end
    end else if ((src == WB_ALU) || !alu_valid_i) begin
      state_d = LSU_FIRST;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= LSU_FIRST;
      cnt_q         <= '0;
      reg_write_q   <= 1'b0;
      write_index_q <= '0;
      write_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reg_write_q <= reg_write_d;
      if (reg_write_d) begin
        write_index_q <= grant_rd;
        write_data_q  <= grant_data;
      end
    end
  end

  assign reg_write_o   = reg_write_q;
  assign write_index_o = write_index_q;
  assign write_data_o  = write_data_q;

  rf_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .set_valid_i (issue_valid_i),
    .set_rd_i    (issue_rd_i),
    .clr_valid_i (reg_write_q),
    .clr_rd_i    (write_index_q),
    .mask_o      (pending_mask_o),
    .err_o       (protocol_err_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_rf_writeback_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_rf_writeback_arbiter
// Vector table plus write scoreboard for the RF writeback arbiter.
// Rev     : 1.0
//------------------------------------------------------------------------------
module tb_rf_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid_i, lsu_valid_i, issue_valid_i;
  logic [4:0]  alu_rd_i, lsu_rd_i, issue_rd_i;
  logic [31:0] alu_data_i, lsu_data_i;
  logic        alu_ready_o, lsu_ready_o, reg_write_o, protocol_err_o;
  logic [4:0]  write_index_o;
  logic [31:0] write_data_o;
  logic [31:0] pending_mask_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        alu_v;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_v;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        iss_v;
    logic [4:0]  iss_rd;
    logic        exp_alu;
    logic        exp_lsu;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  idx;
    logic [31:0] data;
  } wr_t;

  wr_t  sbq[$];
  vec_t tbl[12];

  rf_writeback_arbiter #(
    .STARVE_LIMIT (4),
    .NREGS        (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .alu_valid_i    (alu_valid_i),
    .alu_rd_i       (alu_rd_i),
    .alu_data_i     (alu_data_i),
    .alu_ready_o    (alu_ready_o),
    .lsu_valid_i    (lsu_valid_i),
    .lsu_rd_i       (lsu_rd_i),
    .lsu_data_i     (lsu_data_i),
    .lsu_ready_o    (lsu_ready_o),
    .issue_valid_i  (issue_valid_i),
    .issue_rd_i     (issue_rd_i),
    .reg_write_o    (reg_write_o),
    .write_index_o  (write_index_o),
    .write_data_o   (write_data_o),
    .pending_mask_o (pending_mask_o),
    .protocol_err_o (protocol_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                              input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                              input logic iv, input logic [4:0] ird,
                              input logic ea, input logic el);
    vec_t v;
    v.alu_v = av; v.alu_rd = ard; v.alu_data = ad;
    v.lsu_v = lv; v.lsu_rd = lrd; v.lsu_data = ld;
    v.iss_v = iv; v.iss_rd = ird;
    v.exp_alu = ea; v.exp_lsu = el;
    return v;
  endfunction

  // Called at posedge+1: drives one cycle, checks readies, then checks the registered write.
  task automatic apply(input vec_t v, input string name);
    wr_t e, got;
    alu_valid_i = v.alu_v; alu_rd_i = v.alu_rd; alu_data_i = v.alu_data;
    lsu_valid_i = v.lsu_v; lsu_rd_i = v.lsu_rd; lsu_data_i = v.lsu_data;
    issue_valid_i = v.iss_v; issue_rd_i = v.iss_rd;
    #3;
    chk({name, " alu_ready"}, {31'd0, alu_ready_o}, {31'd0, v.exp_alu});
    chk({name, " lsu_ready"}, {31'd0, lsu_ready_o}, {31'd0, v.exp_lsu});
    chk({name, " one_ready"}, {31'd0, alu_ready_o & lsu_ready_o}, 32'd0);
    e.we = 1'b0; e.idx = '0; e.data = '0;
    if (v.exp_lsu && v.lsu_rd != 5'd0) begin
      e.we = 1'b1; e.idx = v.lsu_rd; e.data = v.lsu_data;
    end else if (v.exp_alu && v.alu_rd != 5'd0) begin
      e.we = 1'b1; e.idx = v.alu_rd; e.data = v.alu_data;
    end
    sbq.push_back(e);
    @(posedge clk); #1;
    got = sbq.pop_front();
    chk({name, " reg_write"}, {31'd0, reg_write_o}, {31'd0, got.we});
    if (got.we) begin
      chk({name, " write_index"}, {27'd0, write_index_o}, {27'd0, got.idx});
      chk({name, " write_data"}, write_data_o, got.data);
    end
  endtask

  initial begin
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    tbl[0] = mk(1, 5'd3, 32'hDEADBEEF, 0, 5'd0, 32'h0, 0, 0, 1, 0);
    for (int i = 1; i <= 8; i++) begin
      tbl[i] = mk(1, 5'd10, 32'hA0A0_0010, 1, 5'd11, 32'h1100_0000 + i, 0, 0,
                  (i == 5), (i != 5));
    end
    tbl[9]  = idle;
    tbl[10] = mk(0, 5'd0, 32'h0, 1, 5'd0, 32'hBAD0_0000, 1, 5'd0, 0, 1);
    tbl[11] = mk(1, 5'd0, 32'hBAD0_0001, 0, 5'd0, 32'h0, 0, 0, 1, 0);

    rst = 1'b1;
    alu_valid_i = 0; alu_rd_i = 0; alu_data_i = 0;
    lsu_valid_i = 0; lsu_rd_i = 0; lsu_data_i = 0;
    issue_valid_i = 0; issue_rd_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset reg_write", {31'd0, reg_write_o}, 32'd0);
    chk("reset write_index", {27'd0, write_index_o}, 32'd0);
    chk("reset write_data", write_data_o, 32'd0);
    chk("reset pending_mask", pending_mask_o, 32'd0);
    chk("reset protocol_err", {31'd0, protocol_err_o}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end
    chk("x0 pending_mask", pending_mask_o, 32'd0);

    // Commit of rd=5 coincides with a new issue of rd=5.
    apply(mk(0, 0, 0, 0, 0, 0, 1, 5'd5, 0, 0), "iss5");
    chk("iss5 mask", pending_mask_o, 32'h0000_0020);
    apply(mk(1, 5'd5, 32'h5555_0005, 0, 0, 0, 0, 0, 1, 0), "wb5");
    chk("wb5 mask before commit", pending_mask_o, 32'h0000_0020);
    apply(mk(0, 0, 0, 0, 0, 0, 1, 5'd5, 0, 0), "reiss5");
    chk("reiss5 mask", pending_mask_o, 32'h0000_0020);
    chk("reiss5 err", {31'd0, protocol_err_o}, 32'd0);
    apply(mk(1, 5'd5, 32'h5555_0006, 0, 0, 0, 0, 0, 1, 0), "wb5b");
    apply(idle, "idle5");
    chk("clear5 mask", pending_mask_o, 32'd0);

    // Double issue of rd=7 with no commit in between.
    apply(mk(0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 0), "iss7a");
    chk("iss7a mask", pending_mask_o, 32'h0000_0080);
    chk("iss7a err", {31'd0, protocol_err_o}, 32'd0);
    apply(mk(0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 0), "iss7b");
    chk("iss7b err", {31'd0, protocol_err_o}, 32'd1);
    chk("iss7b mask", pending_mask_o, 32'h0000_0080);
    apply(idle, "idle7a");
    apply(idle, "idle7b");
    chk("err sticky", {31'd0, protocol_err_o}, 32'd1);

    // Reset while a write is on the port.
    alu_valid_i = 1; alu_rd_i = 5'd9; alu_data_i = 32'h9999_0009;
    #3;
    chk("rst9 alu_ready", {31'd0, alu_ready_o}, 32'd1);
    @(posedge clk); #1;
    alu_valid_i = 0;
    chk("rst9 inflight", {31'd0, reg_write_o}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async reg_write", {31'd0, reg_write_o}, 32'd0);
    chk("async write_index", {27'd0, write_index_o}, 32'd0);
    chk("async write_data", write_data_o, 32'd0);
    chk("async pending_mask", pending_mask_o, 32'd0);
    chk("async protocol_err", {31'd0, protocol_err_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst idle%0d", i), {31'd0, reg_write_o}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
